// File: rtl/rapid_pipe_stage.sv
// rapid_pipe_stage: valid/ready pipeline register with a 2-entry skid buffer,
// synchronous flush and a saturating counter of flush-killed entries.
// o_ready and o_valid are decoded from the state register only, so neither
// has a combinational path from i_ready or i_valid.
module rapid_pipe_stage #(
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_flush_kills
);

  // EMPTY: nothing stored; BUSY: main valid; FULL: main (older) and skid (newer) valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // The sum is two bits wider than the counter so adding up to 2 cannot wrap
  // before the saturation compare.
  localparam logic [CNT_W+1:0] KILL_MAX = {2'b00, {CNT_W{1'b1}}};

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_q, main_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    kills_q, kills_d;
  logic                accept, drain;
  logic [1:0]          kill_n;
  logic [CNT_W+1:0]    kill_sum;

  assign o_valid       = (state_q != ST_EMPTY);
  assign o_ready       = (state_q != ST_FULL);
  assign o_data        = main_q;
  assign o_flush_kills = kills_q;

  assign accept = i_valid & o_ready;
  assign drain  = o_valid & i_ready;

  // Occupancy decode from the state register.
  always_comb begin
    unique case (state_q)
      ST_BUSY: o_occupancy = 2'd1;
      ST_FULL: o_occupancy = 2'd2;
      default: o_occupancy = 2'd0;
    endcase
  end

  // Entries killed by a flush: everything stored except one that drains in
  // the same cycle (drain implies occupancy >= 1, so no underflow).
  always_comb begin
    kill_n   = o_occupancy - {1'b0, drain};
    kill_sum = {2'b00, kills_q} + {{CNT_W{1'b0}}, kill_n};
  end

  // Next-state and payload steering; flush overrides every handshake transition.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    kills_d = kills_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
      kills_d = (kill_sum > KILL_MAX) ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_BUSY;
            main_d  = i_data;
          end
        end
        ST_BUSY: begin
          if (accept && drain) begin
            main_d = i_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = i_data;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State, payload and counter registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: the payload registers are reset too, because o_data must read
      // zero out of reset and after a clearing flush.
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      kills_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      kills_q <= kills_d;
    end
  end

endmodule

// File: tb/tb_rapid_pipe_stage.sv
// Testbench for rapid_pipe_stage: directed scenarios followed by random
// traffic, compared against a queue-based reference model. Two instances share
// the stimulus; the second has a 2-bit kill counter to exercise saturation.
module tb_rapid_pipe_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  logic          o_ready, o_valid;
  logic [DW-1:0] o_data;
  logic [1:0]    o_occ;
  logic [15:0]   o_kills;

  logic          s_ready, s_valid;
  logic [DW-1:0] s_data;
  logic [1:0]    s_occ;
  logic [1:0]    s_kills;

  // Reference model state.
  logic [DW-1:0] q[$];
  int            total_kills;
  bit            zeroed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rapid_pipe_stage #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush),
    .i_valid(valid), .o_ready(o_ready), .i_data(data),
    .o_valid(o_valid), .i_ready(ready), .o_data(o_data),
    .o_occupancy(o_occ), .o_flush_kills(o_kills)
  );

  rapid_pipe_stage #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_reset(reset), .i_flush(flush),
    .i_valid(valid), .o_ready(s_ready), .i_data(data),
    .o_valid(s_valid), .i_ready(ready), .o_data(s_data),
    .o_occupancy(s_occ), .o_flush_kills(s_kills)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  // Compare both instances against the model.
  task automatic compare(input string ctx);
    int n;
    n = q.size();
    check({ctx, " occ"},     64'(o_occ),   64'(n));
    check({ctx, " valid"},   64'(o_valid), 64'(n != 0));
    check({ctx, " ready"},   64'(o_ready), 64'(n != 2));
    check({ctx, " kills"},   64'(o_kills), 64'(sat(total_kills, 65535)));
    check({ctx, " s_occ"},   64'(s_occ),   64'(n));
    check({ctx, " s_kills"}, 64'(s_kills), 64'(sat(total_kills, 3)));
    if (n != 0) begin
      check({ctx, " data"},   64'(o_data), 64'(q[0]));
      check({ctx, " s_data"}, 64'(s_data), 64'(q[0]));
    end else if (zeroed) begin
      check({ctx, " data0"},  64'(o_data), 64'd0);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit r, input bit f,
                      input string ctx);
    bit acc, drn;
    valid = v; data = d; ready = r; flush = f;
    acc = v && (q.size() < 2);
    drn = (q.size() > 0) && r;
    @(posedge clk);
    if (f) begin
      total_kills += q.size() - int'(drn);
      q.delete();
      zeroed = 1'b1;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(d);
        zeroed = 1'b0;
      end
    end
    #1;
    compare(ctx);
  endtask

  // Assert reset between edges, check the immediate effect, release between edges.
  task automatic async_reset(input string ctx);
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    total_kills = 0;
    zeroed = 1'b1;
    compare({ctx, " immediate"});
    valid = 1'b0; ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    compare({ctx, " released"});
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0; data = '0;
    total_kills = 0;
    zeroed = 1'b1;
    #13;
    reset = 1'b0;
    @(posedge clk);
    #1;
    compare("reset");

    // Streaming at full throughput.
    step(1'b1, 32'h11, 1'b1, 1'b0, "stream 11");
    step(1'b1, 32'h22, 1'b1, 1'b0, "stream 22");
    step(1'b1, 32'h33, 1'b1, 1'b0, "stream 33");
    step(1'b0, 32'h00, 1'b1, 1'b0, "stream end");

    // Backpressure into the skid register, then drain in order.
    step(1'b1, 32'hA1, 1'b0, 1'b0, "bp A1");
    step(1'b1, 32'hA2, 1'b0, 1'b0, "bp A2");
    check("bp full data", 64'(o_data), 64'hA1);
    step(1'b1, 32'hA3, 1'b0, 1'b0, "bp hold");
    step(1'b0, 32'h00, 1'b1, 1'b0, "bp drain1");
    check("bp ready back", 64'(o_ready), 64'd1);
    step(1'b0, 32'h00, 1'b1, 1'b0, "bp drain2");

    // Flush while FULL kills both entries and clears the payload.
    step(1'b1, 32'hB1, 1'b0, 1'b0, "ff fill1");
    step(1'b1, 32'hB2, 1'b0, 1'b0, "ff fill2");
    step(1'b0, 32'h00, 1'b0, 1'b1, "ff flush");
    check("ff kills2", 64'(o_kills), 64'd2);

    // Flush with simultaneous drain and accept: drain completes, nothing captured.
    step(1'b1, 32'h55, 1'b0, 1'b0, "fda fill");
    step(1'b1, 32'h66, 1'b1, 1'b1, "fda flush");
    check("fda kills", 64'(o_kills), 64'd2);

    // Two more FULL flushes: 6 kills total, 2-bit counter pinned at 3.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, $urandom, 1'b0, 1'b0, "sat fill1");
      step(1'b1, $urandom, 1'b0, 1'b0, "sat fill2");
      step(1'b0, 32'h00, 1'b0, 1'b1, "sat flush");
    end
    check("sat 2bit", 64'(s_kills), 64'd3);
    check("sat 16bit", 64'(o_kills), 64'd6);

    // Async reset while FULL, then first payload after release.
    step(1'b1, 32'hC1, 1'b0, 1'b0, "ar fill1");
    step(1'b1, 32'hC2, 1'b0, 1'b0, "ar fill2");
    async_reset("ar");
    step(1'b1, 32'h77, 1'b0, 1'b0, "ar push77");
    check("ar data77", 64'(o_data), 64'h77);

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 11) == 0, "rand");
      if (i % 700 == 699) async_reset("rand reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rapid_pipe_stage.md
# rapid_pipe_stage

Parametrised inter-stage pipeline register for the RAPID-X core, the generic successor of the fixed decode→execute latch. It carries an arbitrary packed payload with a valid/ready handshake, a 2-entry skid buffer so that `o_ready` never depends combinationally on `i_ready`, a synchronous flush that kills in-flight entries, and a saturating counter of flush-killed entries. It is instantiated between any two core stages (IF/ID, ID/EX, EX/MEM, …), with the payload being the stage's control struct plus operands packed into `DATA_W` bits.

## Interface
Parameters:
- `DATA_W`, 32 — payload width in bits; legal range is 1 or more.
- `CLEAR_ON_FLUSH`, 1 — 1: payload registers are zeroed on flush or reset; 0: payload is retained on flush and is don't-care.
- `CNT_W`, 16 — width of the flush-kill counter; legal range is 1 or more.

Ports:
- `i_clk` — input, 1 — clock; all state updates on its rising edge.
- `i_reset` — input, 1 — asynchronous, active-high reset.
- `i_flush` — input, 1 — synchronous flush (branch/PC reload).
- `i_valid` — input, 1 — upstream has a payload.
- `o_ready` — output, 1 — stage can accept; registered.
- `i_data` — input, `DATA_W` — upstream payload.
- `o_valid` — output, 1 — stage presents a payload downstream; registered.
- `i_ready` — input, 1 — downstream accepts.
- `o_data` — output, `DATA_W` — head payload (main register).
- `o_occupancy` — output, 2 — number of stored entries: 0, 1 or 2.
- `o_flush_kills` — output, `CNT_W` — saturating count of entries discarded by flush.

## Operation
Definitions:
- `accept = i_valid & o_ready`
- `drain = o_valid & i_ready`

States: EMPTY (occupancy 0), BUSY (main register valid), FULL (main and skid registers valid).

Output decode per state:
- `o_valid = (state != EMPTY)`
- `o_ready = (state != FULL)`
- `o_data = main`

Transitions when `i_flush` is 0:
- EMPTY: `accept` → BUSY, main ← `i_data`. Otherwise stay EMPTY.
- BUSY, `accept & drain` → BUSY, main ← `i_data`.
- BUSY, `accept & !drain` → FULL, skid ← `i_data`.
- BUSY, `!accept & drain` → EMPTY.
- BUSY, neither → hold.
- FULL: `drain` → BUSY, main ← skid. Otherwise hold. No accept is possible in FULL because `o_ready` is 0.

Flush (`i_flush` = 1) has priority over every other transition:
- Next state is EMPTY regardless of `accept` or `drain`.
- The `i_data` offered in that cycle is not captured.
- A `drain` in the flush cycle still completes, so the downstream consumer owns that entry.
- If `CLEAR_ON_FLUSH` = 1, main and skid are cleared to 0.
- `o_flush_kills += occupancy - (drain ? 1 : 0)`, saturating at 2^`CNT_W`−1 (never wraps).
- Flush while EMPTY adds 0.

Invariants:
- Ordering is FIFO: main is always the older entry and skid the newer.
- No entry is duplicated or dropped except by flush.

Reset (asynchronous):
- state = EMPTY, `o_valid` = 0, `o_ready` = 1, `o_occupancy` = 0.
- main = skid = 0, `o_flush_kills` = 0.
- Reset asserted mid-transfer overrides everything immediately; no kills are counted.

## Timing
- Latency is 1 cycle: a payload accepted at edge N appears on `o_data` with `o_valid` high after edge N.
- Throughput is 1 payload per cycle while `i_ready` stays high; occupancy stays at 1.
- `o_ready` and `o_valid` are pure functions of registered state, so there is no combinational path from `i_ready` or `i_valid`.
- `o_data` is a direct register output.
- After `i_ready` falls, at most one more payload is accepted (into skid), then `o_ready` drops at the following edge.
- From FULL, `o_ready` returns to 1 one cycle after the first `drain`.
- The flush effect is visible after the next edge: `o_valid` = 0, `o_ready` = 1.
- The `o_flush_kills` update is visible on the same edge as the flush.
- The counter never decrements; only reset clears it.

## Test plan
- **Streaming:** `i_ready` = 1, `i_valid` = 1 with payloads 0x11, 0x22, 0x33 on consecutive cycles. Required: `o_data` shows 0x11, 0x22, 0x33 one cycle later each; `o_occupancy` stays 1; `o_ready` stays 1.
- **Backpressure/skid:** hold `i_ready` = 0 and push 0xA1 then 0xA2. Required: state goes FULL, `o_ready` = 0, `o_occupancy` = 2, `o_data` = 0xA1. Then raise `i_ready`. Required: 0xA1 then 0xA2 delivered in order, `o_ready` = 1 one cycle after the first drain.
- **Flush while FULL:** occupancy 2, `i_ready` = 0, pulse `i_flush`. Required: next cycle EMPTY, `o_valid` = 0, `o_data` = 0 (`CLEAR_ON_FLUSH` = 1), `o_flush_kills` = 2.
- **Flush with simultaneous drain and accept:** BUSY holding 0x55, `i_ready` = 1, `i_valid` = 1 with 0x66, `i_flush` = 1. Required: 0x55 consumed, 0x66 not captured, state EMPTY, kills +0.
- **Counter saturation:** with `CNT_W` = 2, perform 3 flushes each killing 2 entries. Required: `o_flush_kills` = 3 and holding, not wrapping.
- **Async reset mid-operation:** in FULL, assert `i_reset` between clock edges. Required: immediately `o_valid` = 0, `o_ready` = 1, `o_occupancy` = 0, counter = 0. After release, the first pushed payload 0x77 appears after 1 cycle.
